mips_boot_loader: RTL and testbench
===================================

# mips_boot_loader

Program loader and result collector sitting directly upstream of the `mips_32` core. It accepts a segmented word stream over a valid/ready handshake and writes instruction and data words into the core's word memory. It then releases the core to run and waits for it to halt. Finally it reads back one result word and presents it, with the run-cycle count, on a valid/ready response port.

## Interface
Parameters:
- `ADDR_W`, 10: word-address width; memory depth is `DEPTH = 2**ADDR_W` words.
- `MAX_CYCLES`, 4096: run-time limit in clocks before a timeout error is raised.

Ports:
- `clk1`  in  1: the only clock; everything is updated on its rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `s_valid`  in  1: stream word valid.
- `s_ready`  out  1: loader can accept a stream word.
- `s_data`  in  32: stream word, either a header or a payload word.
- `s_last`  in  1: marks the final word of the whole program image.
- `mem_we`  out  1: memory write strobe.
- `mem_addr`  out  ADDR_W: memory word address, used for writes and for the result read.
- `mem_wdata`  out  32: memory write data.
- `mem_rdata`  in  32: memory read data, valid one cycle after `mem_addr` is presented.
- `cpu_run`  out  1: high releases the core from halt; low holds it.
- `cpu_halted`  in  1: core HALTED flag, a level signal.
- `res_addr`  in  ADDR_W: address of the result word; sampled when RUN is entered.
- `res_valid`  out  1: response valid.
- `res_ready`  in  1: response consumed.
- `res_data`  out  32: result word.
- `res_cycles`  out  16: number of clocks spent in RUN, saturating at 16'hFFFF.
- `err`  out  1: sticky error flag, cleared only by `reset`.
- `busy`  out  1: high in every state except IDLE.

## Operation
Stream format:
- Header word: bits [31:16] are the base word address; bits [15:0] are the count N.
- The header is followed by N payload words, written to addresses base, base+1, ... base+N-1.
- Segments repeat back to back.
- Loading ends on the accepted word that carries `s_last`. This is either the last payload word of a segment, or a header with N=0.
- `s_last` on any other word (a mid-segment payload word, or a header with N>0) sets `err` and ends loading immediately.

Range checks, done when a header is accepted:
- If base+N > DEPTH, or base[15:ADDR_W] is nonzero, then `err` is set.
- The segment's payload is still consumed (`s_ready` stays high), but `mem_we` is suppressed for that segment.
- Addresses never wrap.

State machine:
- IDLE, waiting for a header:
  - Header with N>0 goes to LOAD.
  - Header with N=0 and `s_last` goes to RUN.
  - Header with N=0 and no `s_last` stays in IDLE.
- LOAD: counts down the remaining payload words.
  - When the count reaches 0 and `s_last` is low, go to IDLE.
  - When the count reaches 0 and `s_last` is high, go to RUN.
- RUN:
  - `cpu_run`=1 and the cycle counter increments every clock.
  - Go to READ when `cpu_halted`=1, sampled only from the second RUN cycle onward.
  - Go to READ, with `err` set, when the counter reaches MAX_CYCLES.
- READ, two cycles:
  - Cycle 1 drives `mem_addr`=latched `res_addr`.
  - Cycle 2 captures `mem_rdata` into `res_data`.
- RESP: `res_valid`=1. When `res_valid`&&`res_ready`, go to IDLE, ready for a new program.

If `err` is set by an `s_last` violation, the loader still proceeds to RUN. The bench must observe `err` to distinguish this case.

## Timing
- Reset values: `s_ready`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `cpu_run`=0, `res_valid`=0, `res_data`=0, `res_cycles`=0, `err`=0, `busy`=0.
- `s_ready`=1 during IDLE and LOAD, from the first cycle after `reset` is released.
- A stream transfer is `s_valid`&&`s_ready` at an edge.
- Write outputs are registered. A payload accepted at edge k shows `mem_we`/`mem_addr`/`mem_wdata` during cycle k+1, held for exactly one cycle. Maximum throughput is 1 word per clock.
- `cpu_run` rises on the first cycle after the transfer that ends loading, and falls on the edge that leaves RUN.
- `res_cycles` is the number of cycles `cpu_run` was high.
- `res_valid` rises 2 cycles after `cpu_run` falls. `res_data` and `res_cycles` are held stable while `res_valid`=1 and `res_ready`=0.
- `reset` asserted in any state returns to IDLE on that edge, with all outputs at their reset values. No further `mem_we` is issued for words in flight.

## Test plan
- Load 11 instruction words at base 0, then a 1-word segment at base 200 with value 5 and `s_last`. The memory/core model halts after 40 run cycles, with MEM[198]=120. Required: 12 single-cycle writes to the correct addresses, `cpu_run` high for exactly 40 cycles, then `res_valid` with `res_data`=120, `res_cycles`=40, `err`=0.
- Same image with random `s_valid` gaps, and `res_ready` held low for 5 cycles. Required: identical writes and response; response values held stable while stalled.
- Header base=1020, N=8 at DEPTH=1024. Required: `err`=1, no `mem_we` for that segment, 8 payload words still accepted.
- `cpu_halted` never asserts, MAX_CYCLES=100. Required: `cpu_run` falls after 100 cycles, `err`=1, `res_cycles`=100.
- `reset` pulsed mid-LOAD, after 3 of 6 payload words. Required: all outputs return to zero on that edge, no further writes, and a fresh header is accepted afterwards.
- `s_last` on the 2nd payload word of a 4-word segment. Required: `err`=1, RUN entered on the next cycle.

Source files
------------

// File: rtl/mips_boot_loader.sv
// mips_boot_loader: program loader and result collector for the mips_32 core.
//
// Accepts a segmented word stream (header {base[31:16], count[15:0]} followed by
// count payload words), writes payload into the core's word memory, releases the
// core, waits for HALTED (or a cycle limit), reads one result word back and
// presents it with the run-cycle count on a valid/ready response port.
//
// Ports:
//   clk1, reset                     clock, synchronous active-high reset
//   s_valid/s_ready/s_data/s_last   program image stream
//   mem_we/mem_addr/mem_wdata       registered memory write port (also result read addr)
//   mem_rdata                       memory read data, one cycle after mem_addr
//   cpu_run/cpu_halted              core run enable / halted level
//   res_addr                        result word address, latched on RUN entry
//   res_valid/res_ready/res_data/res_cycles   response port
//   err                             sticky error flag
//   busy                            high in every state except IDLE
module mips_boot_loader #(
  parameter int unsigned ADDR_W     = 10,
  parameter int unsigned MAX_CYCLES = 4096
) (
  input  logic              clk1,
  input  logic              reset,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [31:0]       s_data,
  input  logic              s_last,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic              cpu_run,
  input  logic              cpu_halted,
  input  logic [ADDR_W-1:0] res_addr,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [31:0]       res_data,
  output logic [15:0]       res_cycles,
  output logic              err,
  output logic              busy
);

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StRun,
    StRead1,
    StRead2,
    StResp
  } state_t;

  localparam logic [16:0] DEPTH     = 17'(1 << ADDR_W);
  localparam logic [31:0] MAX_C     = 32'(MAX_CYCLES);

  state_t              r_state;
  logic                r_s_ready;
  logic                r_mem_we;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [31:0]         r_mem_wdata;
  logic                r_cpu_run;
  logic                r_res_valid;
  logic [31:0]         r_res_data;
  logic [15:0]         r_res_cycles;
  logic                r_err;
  logic                r_busy;
  logic [ADDR_W-1:0]   r_wr_addr;
  logic [15:0]         r_remain;
  logic                r_seg_bad;
  logic [ADDR_W-1:0]   r_res_addr;
  logic [31:0]         r_run_cnt;

  state_t              w_state_d;
  logic                w_set_err;
  logic                w_xfer;
  logic [15:0]         w_hdr_base;
  logic [15:0]         w_hdr_cnt;
  logic [16:0]         w_hdr_end;
  logic                w_hdr_bad;
  logic [31:0]         w_run_inc;
  logic                w_halt;
  logic                w_tmo;
  logic [15:0]         w_cyc_sat;

  assign w_xfer     = s_valid & r_s_ready;
  assign w_hdr_base = s_data[31:16];
  assign w_hdr_cnt  = s_data[15:0];
  assign w_hdr_end  = {1'b0, w_hdr_base} + {1'b0, w_hdr_cnt};
  // Base beyond the memory covers nonzero base[15:ADDR_W]; end beyond DEPTH
  // rejects segments that would wrap.
  assign w_hdr_bad  = ({1'b0, w_hdr_base} >= DEPTH) || (w_hdr_end > DEPTH);
  assign w_run_inc  = r_run_cnt + 32'd1;
  // HALTED from a previous program may still be high in the first RUN cycle.
  assign w_halt     = (r_run_cnt != 32'd0) && cpu_halted;
  assign w_tmo      = (w_run_inc >= MAX_C);
  assign w_cyc_sat  = (r_run_cnt > 32'h0000_FFFF) ? 16'hFFFF : r_run_cnt[15:0];

  always_comb begin
    w_state_d = r_state;
    w_set_err = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (w_xfer) begin
          if (w_hdr_bad) w_set_err = 1'b1;
          if (w_hdr_cnt != 16'd0) begin
            if (s_last) begin
              w_set_err = 1'b1;
              w_state_d = StRun;
            end else begin
              w_state_d = StLoad;
            end
          end else if (s_last) begin
            w_state_d = StRun;
          end
        end
      end
      StLoad: begin
        if (w_xfer) begin
          if (r_remain == 16'd1) begin
            w_state_d = s_last ? StRun : StIdle;
          end else if (s_last) begin
            w_set_err = 1'b1;
            w_state_d = StRun;
          end
        end
      end
      StRun: begin
        if (w_halt) begin
          w_state_d = StRead1;
        end else if (w_tmo) begin
          w_set_err = 1'b1;
          w_state_d = StRead1;
        end
      end
      StRead1: w_state_d = StRead2;
      StRead2: w_state_d = StResp;
      StResp:  if (res_ready) w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk1) begin
    if (reset) begin
      r_state      <= StIdle;
      r_s_ready    <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_cpu_run    <= 1'b0;
      r_res_valid  <= 1'b0;
      r_res_data   <= '0;
      r_res_cycles <= '0;
      r_err        <= 1'b0;
      r_busy       <= 1'b0;
      r_wr_addr    <= '0;
      r_remain     <= '0;
      r_seg_bad    <= 1'b0;
      r_res_addr   <= '0;
      r_run_cnt    <= '0;
    end else begin
      r_state   <= w_state_d;
      r_s_ready <= (w_state_d == StIdle) || (w_state_d == StLoad);
      r_busy    <= (w_state_d != StIdle);
      r_cpu_run <= (w_state_d == StRun);
      r_mem_we  <= 1'b0;
      if (w_set_err) r_err <= 1'b1;

      unique case (r_state)
        StIdle: begin
          if (w_xfer) begin
            r_wr_addr <= w_hdr_base[ADDR_W-1:0];
            r_remain  <= w_hdr_cnt;
            r_seg_bad <= w_hdr_bad;
          end
        end
        StLoad: begin
          if (w_xfer) begin
            if (!r_seg_bad) begin
              r_mem_we    <= 1'b1;
              r_mem_addr  <= r_wr_addr;
              r_mem_wdata <= s_data;
            end
            r_wr_addr <= r_wr_addr + ADDR_W'(1);
            r_remain  <= r_remain - 16'd1;
          end
        end
        StRun: begin
          r_run_cnt <= w_run_inc;
          // Present the result address during the first READ cycle.
          if (w_state_d != StRun) r_mem_addr <= r_res_addr;
        end
        StRead1: ;
        StRead2: begin
          r_res_data   <= mem_rdata;
          r_res_cycles <= w_cyc_sat;
          r_res_valid  <= 1'b1;
        end
        StResp: begin
          if (res_ready) r_res_valid <= 1'b0;
        end
        default: ;
      endcase

      if ((w_state_d == StRun) && (r_state != StRun)) begin
        r_run_cnt  <= '0;
        r_res_addr <= res_addr;
      end
    end
  end

  assign s_ready    = r_s_ready;
  assign mem_we     = r_mem_we;
  assign mem_addr   = r_mem_addr;
  assign mem_wdata  = r_mem_wdata;
  assign cpu_run    = r_cpu_run;
  assign res_valid  = r_res_valid;
  assign res_data   = r_res_data;
  assign res_cycles = r_res_cycles;
  assign err        = r_err;
  assign busy       = r_busy;

endmodule

// File: tb/tb_mips_boot_loader.sv
// Directed testbench for mips_boot_loader with a word-memory and halting-core model.
module tb_mips_boot_loader;

  logic        clk1 = 1'b0;
  logic        reset = 1'b1;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [31:0] s_data = '0;
  logic        s_last = 1'b0;
  logic        mem_we;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        cpu_run;
  logic        cpu_halted;
  logic [9:0]  res_addr = 10'd198;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [31:0] res_data;
  logic [15:0] res_cycles;
  logic        err;
  logic        busy;

  int checks = 0;
  int errors = 0;

  mips_boot_loader #(
    .ADDR_W    (10),
    .MAX_CYCLES(100)
  ) dut (
    .clk1      (clk1),
    .reset     (reset),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .s_last    (s_last),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .cpu_run   (cpu_run),
    .cpu_halted(cpu_halted),
    .res_addr  (res_addr),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_cycles(res_cycles),
    .err       (err),
    .busy      (busy)
  );

  always #5 clk1 = ~clk1;

  // Memory / core model. The core halts in its halt_at-th run cycle.
  logic [31:0] mem [0:1023];
  bit          preloaded = 1'b0;
  logic [31:0] wr_a [0:63];
  logic [31:0] wr_d [0:63];
  int          wr_n = 0;
  int          run_total = 0;
  int          run_edges = 0;
  int          halt_at = 40;
  bit          halt_en = 1'b1;

  assign cpu_halted = halt_en && (run_edges + 1 >= halt_at);

  always @(posedge clk1) begin
    if (!preloaded) begin
      mem[198]  <= 32'd120;
      preloaded <= 1'b1;
    end
    if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
      if (wr_n < 64) begin
        wr_a[wr_n] <= 32'(mem_addr);
        wr_d[wr_n] <= mem_wdata;
      end
      wr_n <= wr_n + 1;
    end
    mem_rdata <= mem[mem_addr];
    if (cpu_run) begin
      run_total <= run_total + 1;
      run_edges <= run_edges + 1;
    end else begin
      run_edges <= 0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ctl"}, 32'({s_ready, mem_we, cpu_run, res_valid, err, busy}), 32'd0);
    chk({tag, "_addr"}, 32'(mem_addr), 32'd0);
    chk({tag, "_wdata"}, mem_wdata, 32'd0);
    chk({tag, "_rdata"}, res_data, 32'd0);
    chk({tag, "_rcyc"}, 32'(res_cycles), 32'd0);
  endtask

  // Drives one word at a negedge, returns at the negedge after it was accepted.
  task automatic send(input logic [31:0] d, input logic l, input int gap);
    int n;
    s_valid = 1'b0;
    repeat (gap) @(negedge clk1);
    s_valid = 1'b1;
    s_data  = d;
    s_last  = l;
    n = 0;
    while (!s_ready && n < 50) begin
      @(negedge clk1);
      n++;
    end
    if (n == 50) chk("send_ready_timeout", 32'(s_ready), 32'd1);
    @(negedge clk1);
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic wait_resp(input string tag);
    int n;
    n = 0;
    while (!res_valid && n < 400) begin
      @(negedge clk1);
      n++;
    end
    chk({tag, "_resp_valid"}, 32'(res_valid), 32'd1);
  endtask

  task automatic resp_ack(input string tag);
    res_ready = 1'b1;
    @(negedge clk1);
    res_ready = 1'b0;
    chk({tag, "_ack_valid"}, 32'(res_valid), 32'd0);
    chk({tag, "_ack_busy"}, 32'(busy), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk1);
    reset     = 1'b1;
    s_valid   = 1'b0;
    s_last    = 1'b0;
    res_ready = 1'b0;
    repeat (2) @(negedge clk1);
    reset = 1'b0;
    @(negedge clk1);
  endtask

  // 11 instruction words at 0, then value 5 at 200 carrying s_last.
  task automatic load_image(input string tag, input int gapmax);
    send({16'd0, 16'd11}, 1'b0, int'($urandom_range(0, gapmax)));
    for (int i = 0; i < 11; i++) begin
      send(32'h2001_0000 + i, 1'b0, int'($urandom_range(0, gapmax)));
      if (i == 0) begin
        chk({tag, "_first_we"}, 32'(mem_we), 32'd1);
        chk({tag, "_first_addr"}, 32'(mem_addr), 32'd0);
      end
    end
    send({16'd200, 16'd1}, 1'b0, int'($urandom_range(0, gapmax)));
    send(32'd5, 1'b1, int'($urandom_range(0, gapmax)));
    chk({tag, "_last_we"}, 32'(mem_we), 32'd1);
    chk({tag, "_last_addr"}, 32'(mem_addr), 32'd200);
    chk({tag, "_run_rise"}, 32'(cpu_run), 32'd1);
  endtask

  task automatic chk_image_writes(input string tag, input int wr0);
    chk({tag, "_nwrites"}, 32'(wr_n - wr0), 32'd12);
    for (int i = 0; i < 11; i++) begin
      chk({tag, "_wa"}, wr_a[wr0 + i], 32'(i));
      chk({tag, "_wd"}, wr_d[wr0 + i], 32'h2001_0000 + 32'(i));
    end
    chk({tag, "_wa_last"}, wr_a[wr0 + 11], 32'd200);
    chk({tag, "_wd_last"}, wr_d[wr0 + 11], 32'd5);
  endtask

  initial begin
    int wr0;
    int rt0;

    // Reset state
    repeat (3) @(negedge clk1);
    chk_reset_vals("reset");
    reset = 1'b0;
    @(negedge clk1);
    chk("post_reset_ready", 32'(s_ready), 32'd1);
    chk("post_reset_busy", 32'(busy), 32'd0);

    // 1: back-to-back image, core halts after 40 cycles
    halt_at = 40;
    wr0 = wr_n;
    rt0 = run_total;
    load_image("t1", 0);
    wait_resp("t1");
    chk_image_writes("t1", wr0);
    chk("t1_run_cycles", 32'(run_total - rt0), 32'd40);
    chk("t1_res_data", res_data, 32'd120);
    chk("t1_res_cycles", 32'(res_cycles), 32'd40);
    chk("t1_err", 32'(err), 32'd0);
    chk("t1_busy", 32'(busy), 32'd1);
    resp_ack("t1");
    chk("t1_ready_again", 32'(s_ready), 32'd1);

    // 2: random s_valid gaps, response stalled for 5 cycles
    wr0 = wr_n;
    rt0 = run_total;
    load_image("t2", 2);
    wait_resp("t2");
    chk_image_writes("t2", wr0);
    chk("t2_run_cycles", 32'(run_total - rt0), 32'd40);
    for (int i = 0; i < 5; i++) begin
      chk("t2_stall_valid", 32'(res_valid), 32'd1);
      chk("t2_stall_data", res_data, 32'd120);
      chk("t2_stall_cycles", 32'(res_cycles), 32'd40);
      @(negedge clk1);
    end
    chk("t2_err", 32'(err), 32'd0);
    resp_ack("t2");

    // 3: out-of-range segment at 1020 with 8 words
    do_reset();
    halt_at = 5;
    wr0 = wr_n;
    send({16'd1020, 16'd8}, 1'b0, 0);
    chk("t3_err_hdr", 32'(err), 32'd1);
    for (int i = 0; i < 8; i++) send(32'hBAD0_0000 + i, (i == 7), 0);
    chk("t3_run_rise", 32'(cpu_run), 32'd1);
    chk("t3_no_we", 32'(mem_we), 32'd0);
    wait_resp("t3");
    chk("t3_nwrites", 32'(wr_n - wr0), 32'd0);
    chk("t3_res_cycles", 32'(res_cycles), 32'd5);
    chk("t3_err", 32'(err), 32'd1);
    resp_ack("t3");

    // 4: core never halts, limit of 100 cycles
    do_reset();
    halt_en = 1'b0;
    rt0 = run_total;
    send({16'd0, 16'd0}, 1'b1, 0);
    chk("t4_run_rise", 32'(cpu_run), 32'd1);
    chk("t4_err_early", 32'(err), 32'd0);
    wait_resp("t4");
    chk("t4_run_cycles", 32'(run_total - rt0), 32'd100);
    chk("t4_err", 32'(err), 32'd1);
    chk("t4_res_cycles", 32'(res_cycles), 32'd100);
    chk("t4_res_data", res_data, 32'd120);
    resp_ack("t4");
    halt_en = 1'b1;

    // 5: reset after 3 of 6 payload words
    do_reset();
    wr0 = wr_n;
    send({16'd300, 16'd6}, 1'b0, 0);
    for (int i = 0; i < 3; i++) send(32'hA0 + i, 1'b0, 0);
    chk("t5_third_we", 32'(mem_we), 32'd1);
    s_valid = 1'b1;
    s_data  = 32'hA3;
    reset   = 1'b1;
    @(negedge clk1);
    chk_reset_vals("t5_reset");
    @(negedge clk1);
    reset   = 1'b0;
    s_valid = 1'b0;
    repeat (2) @(negedge clk1);
    chk("t5_nwrites", 32'(wr_n - wr0), 32'd3);
    chk("t5_wa2", wr_a[wr0 + 2], 32'd302);
    chk("t5_wd2", wr_d[wr0 + 2], 32'hA2);
    chk("t5_busy", 32'(busy), 32'd0);
    halt_at = 3;
    send({16'd400, 16'd1}, 1'b0, 0);
    send(32'hABC, 1'b1, 0);
    wait_resp("t5");
    chk("t5_nwrites2", 32'(wr_n - wr0), 32'd4);
    chk("t5_wa3", wr_a[wr0 + 3], 32'd400);
    chk("t5_wd3", wr_d[wr0 + 3], 32'hABC);
    chk("t5_res_cycles", 32'(res_cycles), 32'd3);
    chk("t5_err", 32'(err), 32'd0);
    resp_ack("t5");

    // 6: s_last on the 2nd word of a 4-word segment
    do_reset();
    halt_at = 2;
    wr0 = wr_n;
    send({16'd500, 16'd4}, 1'b0, 0);
    send(32'hC0, 1'b0, 0);
    chk("t6_err_before", 32'(err), 32'd0);
    send(32'hC1, 1'b1, 0);
    chk("t6_run_rise", 32'(cpu_run), 32'd1);
    chk("t6_err", 32'(err), 32'd1);
    chk("t6_s_ready", 32'(s_ready), 32'd0);
    wait_resp("t6");
    chk("t6_nwrites", 32'(wr_n - wr0), 32'd2);
    chk("t6_wa1", wr_a[wr0 + 1], 32'd501);
    chk("t6_res_cycles", 32'(res_cycles), 32'd2);
    resp_ack("t6");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
